// File: rtl/alu_div8b.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock,
// start/busy/done handshake, results held until the next accepted start.
module alu_div8b #(
    parameter int DATASIZE = 8
) (
    input  logic                iCLK,
    input  logic                iRST,
    input  logic                iStart,
    input  logic [DATASIZE-1:0] iDvd,
    input  logic [DATASIZE-1:0] iDvs,
    output logic [DATASIZE-1:0] oQuo,
    output logic [DATASIZE-1:0] oRem,
    output logic                oBusy,
    output logic                oDone,
    output logic                oDivZ
);

    localparam int CW = $clog2(DATASIZE + 1);
    localparam logic [CW-1:0] LAST = CW'(DATASIZE - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATASIZE-1:0]   prem_q, prem_d;
    logic [DATASIZE-1:0]   sdvd_q, sdvd_d;
    logic [DATASIZE-1:0]   dvs_q, dvs_d;
    logic [DATASIZE-1:0]   quo_q, quo_d;
    logic [DATASIZE-1:0]   rem_q, rem_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  divz_q, divz_d;

    logic [DATASIZE:0]     shifted;
    logic [DATASIZE+1:0]   diff;
    logic                  borrow;
    logic [DATASIZE-1:0]   iter_rem;
    logic [DATASIZE:0]     iter_dvd;

    // Trial subtraction as A + ~B + 1 one bit wider than the shifted
    // remainder; the extra carry-out bit tells us whether a borrow occurred.
    always_comb begin
        shifted  = {prem_q, sdvd_q[DATASIZE-1]};
        diff     = {1'b0, shifted} + {1'b0, ~{1'b0, dvs_q}} + {{(DATASIZE+1){1'b0}}, 1'b1};
        borrow   = ~diff[DATASIZE+1];
        iter_rem = borrow ? shifted[DATASIZE-1:0] : diff[DATASIZE-1:0];
        iter_dvd = {sdvd_q, ~borrow};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prem_d  = prem_q;
        sdvd_d  = sdvd_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        divz_d  = divz_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (iStart) begin
                    sdvd_d = iDvd;
                    dvs_d  = iDvs;
                    prem_d = '0;
                    cnt_d  = '0;
                    if (iDvs != '0) begin
                        state_d = CALC;
                        busy_d  = 1'b1;
                        divz_d  = 1'b0;
                    end else begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        divz_d  = 1'b1;
                        quo_d   = '1;
                        rem_d   = iDvd;
                    end
                end
            end
            CALC: begin
                prem_d = iter_rem;
                sdvd_d = iter_dvd[DATASIZE-1:0];
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    quo_d   = iter_dvd[DATASIZE-1:0];
                    rem_d   = iter_rem;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prem_q  <= '0;
            sdvd_q  <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            divz_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prem_q  <= prem_d;
            sdvd_q  <= sdvd_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            divz_q  <= divz_d;
        end
    end

    assign oQuo  = quo_q;
    assign oRem  = rem_q;
    assign oBusy = busy_q;
    assign oDone = done_q;
    assign oDivZ = divz_q;

endmodule
